// File: rtl/rr_grant_pkg.sv
// Shared types and constants for the round-robin grant sequencer.
package rr_grant_pkg;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    localparam int C_ACTIVE_HIGH = 1;
    localparam int C_ACTIVE_LOW  = 0;

    function automatic int clog2(input int value);
        int res;
        res = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 << i) < value) begin
                res = i + 1;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/rr_grant_sequencer_if.sv
// Request/grant bundle between requesters (master) and the arbiter (slave).
interface rr_grant_sequencer_if #(
    parameter int C_NUM_REQ   = 4,
    parameter int C_SEL_WIDTH = 2
);
    logic [C_NUM_REQ-1:0]   REQ;
    logic                   DONE;
    logic [C_SEL_WIDTH-1:0] GNT_SEL;
    logic [C_NUM_REQ-1:0]   GNT;
    logic                   VALID;
    logic                   TIMEOUT;

    modport master (output REQ, DONE, input GNT_SEL, GNT, VALID, TIMEOUT);
    modport slave  (input REQ, DONE, output GNT_SEL, GNT, VALID, TIMEOUT);
endinterface

// File: rtl/rr_grant_decode.sv
// Binary-to-one-hot decoder with enable; all bits inactive when disabled.
module rr_grant_decode
    import rr_grant_pkg::*;
#(
    parameter int C_NUM_OUT   = 4,
    parameter int C_SEL_WIDTH = 2,
    parameter int C_POLARITY  = C_ACTIVE_HIGH
) (
    input  logic [C_SEL_WIDTH-1:0] sel_s,
    input  logic                   en_s,
    output logic [C_NUM_OUT-1:0]   dec_s
);

    logic [C_NUM_OUT-1:0] hot_s;

    // Active-high one-hot decode gated by the enable
    always_comb begin
        hot_s = '0;
        for (int i = 0; i < C_NUM_OUT; i++) begin
            if (en_s && (sel_s == C_SEL_WIDTH'(i))) begin
                hot_s[i] = 1'b1;
            end else begin
                hot_s[i] = 1'b0;
            end
        end
    end

    assign dec_s = (C_POLARITY == C_ACTIVE_LOW) ? ~hot_s : hot_s;

endmodule

// File: rtl/rr_grant_sequencer.sv
// Round-robin arbiter with hold limit; registered grant index, decoded grant vector.
module rr_grant_sequencer
    import rr_grant_pkg::*;
#(
    parameter int C_NUM_REQ   = 4,
    parameter int C_SEL_WIDTH = 2,
    parameter int C_OUT_HIGH  = 1,
    parameter int C_MAX_HOLD  = 8,
    parameter int C_HAS_CE    = 0
) (
    input  logic                 CLK,
    input  logic                 SCLR_N,
    input  logic                 CE,
    rr_grant_sequencer_if.slave  bus
);

    localparam int C_CNT_W = (clog2(C_MAX_HOLD) < 1) ? 1 : clog2(C_MAX_HOLD);

    state_t                 state_r;
    logic [C_SEL_WIDTH-1:0] sel_r;
    logic [C_SEL_WIDTH-1:0] ptr_r;
    logic [C_CNT_W-1:0]     cnt_r;
    logic                   valid_r;
    logic                   timeout_r;

    logic                   ce_s;
    logic [C_SEL_WIDTH-1:0] base_s;
    logic [C_NUM_REQ-1:0]   req_mask_s;
    logic                   win_vld_s;
    logic [C_SEL_WIDTH-1:0] win_sel_s;
    logic                   hold_hit_s;
    logic                   release_s;

    assign ce_s       = (C_HAS_CE == 0) ? 1'b1 : CE;
    assign base_s     = (state_r == ST_GRANT) ? sel_r : ptr_r;
    assign hold_hit_s = (C_MAX_HOLD > 0) && (cnt_r == C_CNT_W'(C_MAX_HOLD - 1));
    assign release_s  = bus.DONE || !bus.REQ[sel_r] || hold_hit_s;

    // Owner is excluded on a voluntary release; on a timeout it merely ranks last
    always_comb begin
        req_mask_s = bus.REQ;
        if ((state_r == ST_GRANT) && (bus.DONE || !bus.REQ[sel_r])) begin
            req_mask_s[sel_r] = 1'b0;
        end else begin
            req_mask_s = bus.REQ;
        end
    end

    // Descending scan: the index nearest base+1 is written last and wins
    always_comb begin
        win_vld_s = 1'b0;
        win_sel_s = '0;
        for (int k = C_NUM_REQ; k >= 1; k--) begin
            if (req_mask_s[C_SEL_WIDTH'((int'(base_s) + k) % C_NUM_REQ)]) begin
                win_vld_s = 1'b1;
                win_sel_s = C_SEL_WIDTH'((int'(base_s) + k) % C_NUM_REQ);
            end else begin
                win_vld_s = win_vld_s;
            end
        end
    end

    // Arbitration state, grant registers and hold counter
    always_ff @(posedge CLK) begin
        if (!SCLR_N) begin
            state_r   <= ST_IDLE;
            sel_r     <= '0;
            ptr_r     <= C_SEL_WIDTH'(C_NUM_REQ - 1);
            cnt_r     <= '0;
            valid_r   <= 1'b0;
            timeout_r <= 1'b0;
        end else if (ce_s) begin
            timeout_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    cnt_r <= '0;
                    if (win_vld_s) begin
                        state_r <= ST_GRANT;
                        sel_r   <= win_sel_s;
                        valid_r <= 1'b1;
                    end else begin
                        valid_r <= 1'b0;
                    end
                end
                ST_GRANT: begin
                    if (release_s) begin
                        ptr_r     <= sel_r;
                        cnt_r     <= '0;
                        // DONE or a dropped request takes precedence over the hold limit
                        timeout_r <= hold_hit_s && !bus.DONE && bus.REQ[sel_r];
                        if (win_vld_s) begin
                            sel_r   <= win_sel_s;
                            valid_r <= 1'b1;
                        end else begin
                            state_r <= ST_IDLE;
                            valid_r <= 1'b0;
                        end
                    end else if (cnt_r != '1) begin
                        cnt_r <= cnt_r + C_CNT_W'(1);
                    end else begin
                        cnt_r <= cnt_r;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    valid_r <= 1'b0;
                    cnt_r   <= '0;
                end
            endcase
        end else begin
            state_r <= state_r;
        end
    end

    assign bus.GNT_SEL = sel_r;
    assign bus.VALID   = valid_r;
    assign bus.TIMEOUT = timeout_r;

    rr_grant_decode #(
        .C_NUM_OUT   (C_NUM_REQ),
        .C_SEL_WIDTH (C_SEL_WIDTH),
        .C_POLARITY  (C_OUT_HIGH)
    ) u_decode (
        .sel_s (sel_r),
        .en_s  (valid_r),
        .dec_s (bus.GNT)
    );

endmodule
